// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stage register.
//   - default data/control/destination widths
//   - control-bundle bit indices (RegWrite, MemtoReg, PCtoReg, Halt)
//   - per-edge stage action encoding
//   - saturating increment used by the optional performance counters
package pipeline_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int NUM_CH_DEF = 3;
  localparam int CTRL_W_DEF = 4;
  localparam int DST_W_DEF  = 4;
  localparam int CNT_W      = 16;

  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_PCTOREG  = 1;
  localparam int CTRL_HALT     = 0;

  // What the stage does on the next rising edge.
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2
  } stage_act_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_reg_en.sv
// Generic register with write enable and asynchronous active-low reset to zero.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous reset, active low, clears o_q
//   i_en    - load i_d on the next rising edge when high
//   i_d     - next value
//   o_q     - registered value
module pipe_reg_en #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Pipeline stage register (e.g. MEM/WB) with stall, flush, a sticky halt and
// optional performance counters.
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   defined   -> bubble_cnt / stall_cnt are saturating 16-bit counters
//   undefined -> counters absent, both outputs tied to zero
//
// Ports:
//   clk        - clock, all state on rising edge
//   rst        - asynchronous reset, active low
//   valid_in   - upstream slot holds a real instruction
//   ctrl_in    - control bundle (RegWrite, MemtoReg, PCtoReg, Halt)
//   data_in    - NUM_CH packed data channels, channel k at [k*DATA_W +: DATA_W]
//   dst_in     - destination register index
//   stall      - hold current contents
//   flush      - load a bubble
//   valid_out  - registered valid
//   ctrl_out   - registered control (zero whenever valid_out is zero)
//   data_out   - registered data channels
//   dst_out    - registered destination (zero whenever valid_out is zero)
//   halted     - sticky, set when a valid Halt is captured; cleared by reset only
//   bubble_cnt - edges that loaded valid=0
//   stall_cnt  - edges held by stall
//
// Edge priority: flush > halted-block > stall > load.
module pipeline_stage_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter int DST_W    = DST_W_DEF,
  parameter int HALT_BIT = CTRL_HALT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic [CTRL_W-1:0]        ctrl_in,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [DST_W-1:0]         dst_in,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     valid_out,
  output logic [CTRL_W-1:0]        ctrl_out,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [DST_W-1:0]         dst_out,
  output logic                     halted,
  output logic [CNT_W-1:0]         bubble_cnt,
  output logic [CNT_W-1:0]         stall_cnt
);

  stage_act_e                 w_act;
  logic                       w_en;
  logic                       w_valid_d;
  logic [CTRL_W-1:0]          w_ctrl_d;
  logic [DST_W-1:0]           w_dst_d;
  logic [NUM_CH*DATA_W-1:0]   w_data_d;
  logic                       w_halt_set;

  logic                       r_valid;
  logic [CTRL_W-1:0]          r_ctrl;
  logic [NUM_CH*DATA_W-1:0]   r_data;
  logic [DST_W-1:0]           r_dst;
  logic                       r_halted;

  // Once halted, the stage drains to bubbles; a stall still freezes it, but
  // that freeze is not a stall of live work and is not counted.
  always_comb begin
    w_act = ACT_LOAD;
    if (flush) begin
      w_act = ACT_BUBBLE;
    end else if (r_halted) begin
      w_act = stall ? ACT_HOLD : ACT_BUBBLE;
    end else if (stall) begin
      w_act = ACT_HOLD;
    end
  end

  assign w_en       = (w_act != ACT_HOLD);
  assign w_valid_d  = (w_act == ACT_LOAD) && valid_in;
  // Control and destination are meaningless without a valid instruction, so
  // they are stored as zero; data of an invalid load is kept as presented.
  assign w_ctrl_d   = w_valid_d ? ctrl_in : '0;
  assign w_dst_d    = w_valid_d ? dst_in  : '0;
  assign w_data_d   = (w_act == ACT_BUBBLE) ? '0 : data_in;
  assign w_halt_set = w_valid_d && ctrl_in[HALT_BIT];

  pipe_reg_en #(.W(1)) u_valid (
    .i_clk(clk), .i_rst_n(rst), .i_en(w_en), .i_d(w_valid_d), .o_q(r_valid)
  );

  pipe_reg_en #(.W(CTRL_W)) u_ctrl (
    .i_clk(clk), .i_rst_n(rst), .i_en(w_en), .i_d(w_ctrl_d), .o_q(r_ctrl)
  );

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      pipe_reg_en #(.W(DATA_W)) u_data (
        .i_clk  (clk),
        .i_rst_n(rst),
        .i_en   (w_en),
        .i_d    (w_data_d[k*DATA_W +: DATA_W]),
        .o_q    (r_data[k*DATA_W +: DATA_W])
      );
    end
  endgenerate

  pipe_reg_en #(.W(DST_W)) u_dst (
    .i_clk(clk), .i_rst_n(rst), .i_en(w_en), .i_d(w_dst_d), .o_q(r_dst)
  );

  pipe_reg_en #(.W(1)) u_halted (
    .i_clk(clk), .i_rst_n(rst), .i_en(w_halt_set), .i_d(1'b1), .o_q(r_halted)
  );

`ifdef PIPE_PERF_CNT_EN
  logic             w_bubble_inc;
  logic             w_stall_inc;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_bubble_inc = w_en && !w_valid_d;
  assign w_stall_inc  = (w_act == ACT_HOLD) && !r_halted;

  pipe_reg_en #(.W(CNT_W)) u_bubble_cnt (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_en   (w_bubble_inc),
    .i_d    (sat_inc(r_bubble_cnt)),
    .o_q    (r_bubble_cnt)
  );

  pipe_reg_en #(.W(CNT_W)) u_stall_cnt (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_en   (w_stall_inc),
    .i_d    (sat_inc(r_stall_cnt)),
    .o_q    (r_stall_cnt)
  );

  assign bubble_cnt = r_bubble_cnt;
  assign stall_cnt  = r_stall_cnt;
`else
  assign bubble_cnt = '0;
  assign stall_cnt  = '0;
`endif

  assign valid_out = r_valid;
  assign ctrl_out  = r_ctrl;
  assign data_out  = r_data;
  assign dst_out   = r_dst;
  assign halted    = r_halted;

endmodule

// File: doc/pipeline_stage_reg.md
PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of each data channel.
REQ-002 SHALL have parameter NUM_CH, default 3, number of data channels (ALU result, dmem data, PC).
REQ-003 SHALL have parameter CTRL_W, default 4, control-bundle width (RegWrite, MemtoReg, PCtoReg, Halt).
REQ-004 SHALL have parameter DST_W, default 4, destination-register index width.
REQ-005 SHALL have parameter HALT_BIT, default 0, index of the Halt bit within the control bundle.
REQ-006 SHALL have clk  input  1  single clock; all state on its rising edge.
REQ-007 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have valid_in  input  1  upstream slot holds a real instruction.
REQ-009 SHALL have ctrl_in  input  CTRL_W  control bundle.
REQ-010 SHALL have data_in  input  NUM_CH*DATA_W  packed data channels; channel k at bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have dst_in  input  DST_W  destination register index.
REQ-012 SHALL have stall  input  1  hold current contents.
REQ-013 SHALL have flush  input  1  load a bubble.
REQ-014 SHALL have valid_out  output  1  registered valid.
REQ-015 SHALL have ctrl_out  output  CTRL_W  registered control, forced 0 when valid_out=0.
REQ-016 SHALL have data_out  output  NUM_CH*DATA_W  registered data.
REQ-017 SHALL have dst_out  output  DST_W  registered destination.
REQ-018 SHALL have halted  output  1  sticky: a valid Halt has been captured.
REQ-019 SHALL have bubble_cnt  output  16  bubbles captured (see Configuration).
REQ-020 SHALL have stall_cnt  output  16  cycles held by stall (see Configuration).

Function
REQ-021 Per-edge priority SHALL be: flush > halted-block > stall > load.
REQ-022 Flush SHALL load valid=0 and ctrl, data, dst all zero, regardless of stall.
REQ-023 Once halted=1, every non-stall edge SHALL load a bubble (as flush); valid_in is ignored.
REQ-024 Stall (no flush, not halted) SHALL hold all registers unchanged, counters excepted.
REQ-025 Load SHALL capture valid_in, ctrl_in, data_in, dst_in with one-cycle latency.
REQ-026 A load with valid_in=0 SHALL zero ctrl and dst; data is captured as presented.
REQ-027 halted SHALL set on the edge that loads valid_in=1 with ctrl_in[HALT_BIT]=1; clearable only by reset.
REQ-028 Same-edge valid Halt plus flush SHALL NOT set halted (flush wins).
REQ-029 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-030 bubble_cnt SHALL increment on every edge that loads valid=0 (flush, halted-block, or load of valid_in=0).
REQ-031 stall_cnt SHALL increment on every edge where the stall hold of REQ-024 is applied.

Reset
REQ-032 rst=0 SHALL immediately clear valid_out, ctrl_out, data_out, dst_out, halted, bubble_cnt, stall_cnt, independent of clk.
REQ-033 Reset asserted mid-stall or mid-halt SHALL discard held contents; the first edge after release behaves per REQ-021.

Configuration
REQ-034 Macro PIPE_PERF_CNT_EN: defined -> bubble_cnt/stall_cnt implemented per REQ-029..031.
REQ-035 Without PIPE_PERF_CNT_EN: counters SHALL be absent, both outputs tied to 16'h0000, ports retained.

Structure
REQ-036 Package pipeline_pkg SHALL hold default widths and control-bit indices (REGWRITE=3, MEMTOREG=2, PCTOREG=1, HALT=0).
REQ-037 A sub-module pipe_reg_en (parametrised width, async active-low reset, write enable) SHALL implement every register field.

Verification
REQ-038 Load valid_in=1, ctrl=4'b1000, data={16'h1234,16'hBEEF,16'h0040}, dst=4'h5 -> identical outputs next cycle, halted=0.
REQ-039 Stall 3 cycles after REQ-038 load with changing inputs -> outputs unchanged, stall_cnt=3 (0 if macro off).
REQ-040 Stall=1 and flush=1 together -> valid_out=0, ctrl_out=0, dst_out=0, data_out=0, bubble_cnt+1.
REQ-041 Load valid ctrl=4'b0001 -> halted=1; following valid loads -> valid_out=0 each edge; rst pulse -> halted=0.
REQ-042 Preset bubble_cnt=16'hFFFE, flush 3 edges -> 16'hFFFF, holds.
REQ-043 Assert rst between edges while valid_out=1 -> all outputs 0 before next clk edge.
